// File: rtl/led_prog_loader_if.sv
// Byte-stream handshake into the program loader.
//   in_data  : incoming byte (source -> loader)
//   in_valid : in_data is valid (source -> loader)
//   in_ready : loader can accept a byte (loader -> source)
// A byte is consumed on a cycle where in_valid && in_ready.
interface led_prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/led_prog_loader.sv
// Writer side of the LED-sequencer program memory.
// Parses frames of the form HEADER, N, N x (pattern, duration), checksum
// and writes each (pattern, duration) pair as one 16-bit word into the
// program RAM starting at address 0. Holds the sequencer core in reset
// until a frame loads with a matching XOR checksum.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_bus     : byte-stream handshake (slave side)
//   wr_en      : one-cycle program-RAM write strobe
//   wr_addr    : program-RAM write address
//   wr_data    : program-RAM write data {pattern/target, duration}
//   cpu_hold   : sequencer core reset, 1 = core held
//   load_done  : sticky, last frame loaded with a good checksum
//   load_err   : sticky, last frame failed (bad checksum or timeout)
module led_prog_loader #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 50_000_000 / 16
) (
    input  logic                clk,
    input  logic                rst,
    led_prog_loader_if.slave    in_bus,
    output logic                wr_en,
    output logic [7:0]          wr_addr,
    output logic [15:0]         wr_data,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic            wr_en_q, wr_en_d;
    logic [7:0]      wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      chk_q, chk_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic            in_ready_c;
    logic            hs_c;
    logic [7:0]      byte_c;

    // Loader only stalls the source during the single write cycle.
    assign in_ready_c      = (state_q != S_WRITE);
    assign hs_c            = in_bus.in_valid && in_ready_c;
    assign byte_c          = in_bus.in_data;
    assign in_bus.in_ready = in_ready_c;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 16'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
            chk_q      <= 8'd0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        tmo_d      = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Non-header bytes outside a frame are dropped.
                if (hs_c && (byte_c == HEADER)) begin
                    state_d    = S_COUNT;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    wr_addr_d  = 8'd0;
                    chk_d      = 8'd0;
                end
            end
            S_COUNT: begin
                if (hs_c) begin
                    cnt_d   = byte_c;
                    chk_d   = chk_q ^ byte_c;
                    state_d = (byte_c == 8'd0) ? S_CSUM : S_HI;
                end
            end
            S_HI: begin
                if (hs_c) begin
                    wr_data_d[15:8] = byte_c;
                    chk_d           = chk_q ^ byte_c;
                    state_d         = S_LO;
                end
            end
            S_LO: begin
                // Strobe is registered so it lines up with the WRITE cycle.
                if (hs_c) begin
                    wr_data_d[7:0] = byte_c;
                    chk_d          = chk_q ^ byte_c;
                    wr_en_d        = 1'b1;
                    state_d        = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_addr_d = wr_addr_q + 8'd1;
                cnt_d     = cnt_q - 8'd1;
                state_d   = (cnt_q == 8'd1) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (hs_c) begin
                    if (byte_c == chk_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout inside a frame; already-issued writes stay in RAM.
        if ((state_q == S_COUNT || state_q == S_HI ||
             state_q == S_LO || state_q == S_CSUM) && !hs_c) begin
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                state_d = S_ERR;
                err_d   = 1'b1;
                wr_en_d = 1'b0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_led_prog_loader.sv
// Table-driven bench for led_prog_loader: per-cycle vectors of
// {in_valid, in_data, expected outputs after the edge}, plus hand-written
// sequences for the timeout and mid-frame reset cases.
module tb_led_prog_loader;

    localparam int unsigned TMO = 16;

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdat;
        logic        hold;
        logic        done;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    led_prog_loader_if bus ();

    led_prog_loader #(.HEADER(8'hA5), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (bus),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic vld, input logic [7:0] dat, input logic rdy,
                       input logic we, input logic [7:0] addr, input logic [15:0] wdat,
                       input logic hold, input logic done, input logic err);
        vec_t v;
        v.vld = vld; v.dat = dat; v.rdy = rdy; v.we = we; v.addr = addr;
        v.wdat = wdat; v.hold = hold; v.done = done; v.err = err;
        tbl.push_back(v);
    endtask

    // Drive inputs just after an edge, clock once, sample 1 time unit later.
    task automatic step(input logic r, input logic vld, input logic [7:0] dat);
        rst          = r;
        bus.in_valid = vld;
        bus.in_data  = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic rdy, input logic we,
                         input logic [7:0] addr, input logic [15:0] wdat,
                         input logic hold, input logic done, input logic err);
        n_vec++;
        if (bus.in_ready !== rdy || wr_en !== we || wr_addr !== addr ||
            wr_data !== wdat || cpu_hold !== hold || load_done !== done ||
            load_err !== err) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, want rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b",
                     name, bus.in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err,
                     rdy, we, addr, wdat, hold, done, err);
        end
    endtask

    initial begin
        // Garbage in IDLE is ignored.
        add(1, 8'h3C, 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        add(1, 8'h7E, 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        // Good two-word frame; byte 81 is held through the WRITE cycle.
        add(1, 8'hA5, 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        add(1, 8'h02, 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        add(1, 8'hFF, 1, 0, 8'h00, 16'hFF00, 1, 0, 0);
        add(1, 8'h10, 0, 1, 8'h00, 16'hFF10, 1, 0, 0);
        add(1, 8'h81, 1, 0, 8'h01, 16'hFF10, 1, 0, 0);
        add(1, 8'h81, 1, 0, 8'h01, 16'h8110, 1, 0, 0);
        add(1, 8'h00, 0, 1, 8'h01, 16'h8100, 1, 0, 0);
        add(0, 8'h00, 1, 0, 8'h02, 16'h8100, 1, 0, 0);
        add(1, 8'h6C, 1, 0, 8'h02, 16'h8100, 0, 1, 0);
        // Same frame, bad checksum.
        add(1, 8'hA5, 1, 0, 8'h00, 16'h8100, 1, 0, 0);
        add(1, 8'h02, 1, 0, 8'h00, 16'h8100, 1, 0, 0);
        add(1, 8'hFF, 1, 0, 8'h00, 16'hFF00, 1, 0, 0);
        add(1, 8'h10, 0, 1, 8'h00, 16'hFF10, 1, 0, 0);
        add(0, 8'h00, 1, 0, 8'h01, 16'hFF10, 1, 0, 0);
        add(1, 8'h81, 1, 0, 8'h01, 16'h8110, 1, 0, 0);
        add(1, 8'h00, 0, 1, 8'h01, 16'h8100, 1, 0, 0);
        add(0, 8'h00, 1, 0, 8'h02, 16'h8100, 1, 0, 0);
        add(1, 8'h6D, 1, 0, 8'h02, 16'h8100, 1, 0, 1);
        // Empty frame, then a new header re-holds the core.
        add(1, 8'hA5, 1, 0, 8'h00, 16'h8100, 1, 0, 0);
        add(1, 8'h00, 1, 0, 8'h00, 16'h8100, 1, 0, 0);
        add(1, 8'h00, 1, 0, 8'h00, 16'h8100, 0, 1, 0);
        add(1, 8'hA5, 1, 0, 8'h00, 16'h8100, 1, 0, 0);
        // Start of a frame that will time out: N=1, pattern 55.
        add(1, 8'h01, 1, 0, 8'h00, 16'h8100, 1, 0, 0);
        add(1, 8'h55, 1, 0, 8'h00, 16'h5500, 1, 0, 0);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        step(0, 0, 8'h00);
        check("reset", 1, 0, 8'h00, 16'h0000, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(0, tbl[i].vld, tbl[i].dat);
            check($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].addr,
                  tbl[i].wdat, tbl[i].hold, tbl[i].done, tbl[i].err);
        end

        // Silence in LO: error exactly after TMO idle cycles, never a write.
        for (int i = 1; i < int'(TMO); i++) begin
            step(0, 0, 8'h00);
            check($sformatf("tmo_wait%0d", i), 1, 0, 8'h00, 16'h5500, 1, 0, 0);
        end
        step(0, 0, 8'h00);
        check("tmo_expire", 1, 0, 8'h00, 16'h5500, 1, 0, 1);
        step(0, 1, 8'h3C);
        check("err_garbage0", 1, 0, 8'h00, 16'h5500, 1, 0, 1);
        step(0, 1, 8'h7E);
        check("err_garbage1", 1, 0, 8'h00, 16'h5500, 1, 0, 1);

        // Header value inside a frame is data; reset between HI and LO.
        step(0, 1, 8'hA5);
        check("rf_hdr", 1, 0, 8'h00, 16'h5500, 1, 0, 0);
        step(0, 1, 8'h02);
        check("rf_cnt", 1, 0, 8'h00, 16'h5500, 1, 0, 0);
        step(0, 1, 8'hA5);
        check("rf_hi_a5", 1, 0, 8'h00, 16'hA500, 1, 0, 0);
        step(0, 1, 8'h22);
        check("rf_write0", 0, 1, 8'h00, 16'hA522, 1, 0, 0);
        step(0, 0, 8'h00);
        check("rf_post_write", 1, 0, 8'h01, 16'hA522, 1, 0, 0);
        step(0, 1, 8'h33);
        check("rf_hi2", 1, 0, 8'h01, 16'h3322, 1, 0, 0);
        step(1, 1, 8'h44);
        check("rf_rst", 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        step(0, 0, 8'h00);
        check("rf_after_rst", 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        step(0, 1, 8'h44);
        check("rf_lo_dropped", 1, 0, 8'h00, 16'h0000, 1, 0, 0);

        // Fresh frame loads from address 0: chk = 01^AB^CD = 67.
        step(0, 1, 8'hA5);
        check("fr_hdr", 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        step(0, 1, 8'h01);
        check("fr_cnt", 1, 0, 8'h00, 16'h0000, 1, 0, 0);
        step(0, 1, 8'hAB);
        check("fr_hi", 1, 0, 8'h00, 16'hAB00, 1, 0, 0);
        step(0, 1, 8'hCD);
        check("fr_write", 0, 1, 8'h00, 16'hABCD, 1, 0, 0);
        step(0, 0, 8'h00);
        check("fr_csum_wait", 1, 0, 8'h01, 16'hABCD, 1, 0, 0);
        step(0, 1, 8'h67);
        check("fr_done", 1, 0, 8'h01, 16'hABCD, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
